alu_issue_ctrl: RTL and testbench

//  Driving end of the 8-bit ALU interface. Accepts 3-address instructions over a valid/ready

---
 rtl/alu_issue_ctrl_pkg.sv | 23 ++
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_issue_ctrl_regfile.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 84 ++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: widths, opcodes, FSM states and instruction field offsets
package alu_issue_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int REG_AW = 2;
  localparam int NREGS = 2**REG_AW;
  localparam int INSTR_W = 3 + 3*REG_AW;
  localparam int RS2_LSB = 0;
  localparam int RS1_LSB = REG_AW;
  localparam int RD_LSB = 2*REG_AW;
  localparam int OP_LSB = 3*REG_AW;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;
  function automatic logic writes_flags(input logic [2:0] op);
    return op <= OP_NOT;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU bus, completion, flags and debug port
interface alu_issue_ctrl_if
  import alu_issue_ctrl_pkg::*;
;
  logic in_valid;
  logic in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0] alu_op;
  logic [DATA_W-1:0] alu_result;
  logic alu_zero;
  logic alu_carry;
  logic done_valid;
  logic done_wen;
  logic [REG_AW-1:0] done_rd;
  logic [DATA_W-1:0] done_data;
  logic flag_z;
  logic flag_c;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output in_valid, in_instr, in_imm, alu_result, alu_zero, alu_carry, dbg_addr,
    input in_ready, alu_a, alu_b, alu_op, done_valid, done_wen, done_rd, done_data,
          flag_z, flag_c, dbg_data
  );
  modport slave (
    input in_valid, in_instr, in_imm, alu_result, alu_zero, alu_carry, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, done_valid, done_wen, done_rd, done_data,
           flag_z, flag_c, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_issue_ctrl_regfile: NREGS x DATA_W register file, one write port, three async read ports
module alu_issue_ctrl_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  input  logic [REG_AW-1:0] raddr3_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] rdata3_o
);
  logic [DATA_W-1:0] rf_q [NREGS];
  // storage: cleared on reset, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf_q <= '{default: '0};
    else if (we_i) rf_q[waddr_i] <= wdata_i;
  end
  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];
  assign rdata3_o = rf_q[raddr3_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues 3-address instructions to an external ALU and writes results back
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_issue_ctrl_if.slave bus
);
  state_t state_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, res_q, rs1_data, rs2_data;
  logic [2:0] op_q;
  logic [REG_AW-1:0] rd_q;
  logic z_q, c_q, fz_q, fc_q, dv_q, dw_q;
  alu_issue_ctrl_regfile u_rf (
    .clk(clk),
    .rst(rst),
    .we_i(state_q == S_WB && dw_q),
    .waddr_i(rd_q),
    .wdata_i(res_q),
    .raddr1_i(bus.in_instr[RS1_LSB +: REG_AW]),
    .raddr2_i(bus.in_instr[RS2_LSB +: REG_AW]),
    .raddr3_i(bus.dbg_addr),
    .rdata1_o(rs1_data),
    .rdata2_o(rs2_data),
    .rdata3_o(bus.dbg_data)
  );
  // IDLE latches operands, EXEC captures the ALU, WB presents completion and commits flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_ADD;
      rd_q <= '0;
      imm_q <= '0;
      res_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      fz_q <= 1'b0;
      fc_q <= 1'b0;
      dv_q <= 1'b0;
      dw_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          a_q <= rs1_data;
          b_q <= rs2_data;
          op_q <= bus.in_instr[OP_LSB +: 3];
          rd_q <= bus.in_instr[RD_LSB +: REG_AW];
          imm_q <= bus.in_imm;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q <= op_q == OP_LDI ? imm_q : op_q == OP_NOP ? '0 : bus.alu_result;
          z_q <= bus.alu_zero;
          c_q <= bus.alu_carry;
          dv_q <= 1'b1;
          dw_q <= op_q != OP_NOP;
          state_q <= S_WB;
        end
        S_WB: begin
          if (writes_flags(op_q)) begin
            fz_q <= z_q;
            fc_q <= c_q;
          end
          dv_q <= 1'b0;
          dw_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready = state_q == S_IDLE && !rst;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_op = op_q;
  assign bus.done_valid = dv_q;
  assign bus.done_wen = dw_q;
  assign bus.done_rd = rd_q;
  assign bus.done_data = res_q;
  assign bus.flag_z = fz_q;
  assign bus.flag_c = fc_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven and sequence checks of the issue controller against a reference ALU
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if bus();
  alu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic [8:0] alu_full;
  // reference ALU: 9-bit result, bit 8 is carry/borrow
  always_comb begin
    alu_full = '0;
    case (bus.alu_op)
      OP_ADD: alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB: alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_AND: alu_full = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:  alu_full = {1'b0, bus.alu_a | bus.alu_b};
      OP_XOR: alu_full = {1'b0, bus.alu_a ^ bus.alu_b};
      OP_NOT: alu_full = {1'b0, ~bus.alu_a};
      default: alu_full = '0;
    endcase
  end
  assign bus.alu_result = alu_full[7:0];
  assign bus.alu_carry = alu_full[8];
  assign bus.alu_zero = alu_full[7:0] == 8'h00;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm, data;
    logic wen;
    logic [7:0] old;
    logic z, c;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [8:0] instr, input logic [7:0] imm, output int lat);
    int n = 0;
    bus.in_instr = instr;
    bus.in_imm = imm;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_instr = '1;
    bus.in_imm = 8'h5A;
    lat = 0;
    while (!bus.done_valid && lat < 5) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] got[3];
    int k;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_imm = '0;
    bus.dbg_addr = '0;
    vecs[0]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h20, 8'h20, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{OP_SUB, 2'd0, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00, 8'h30, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{OP_NOT, 2'd0, 2'd1, 2'd0, 8'h00, 8'h0F, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[6]  = '{OP_AND, 2'd3, 2'd1, 2'd2, 8'h00, 8'h20, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[7]  = '{OP_OR,  2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 1'b1, 8'h20, 1'b0, 1'b0};
    vecs[8]  = '{OP_XOR, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[9]  = '{OP_ADD, 2'd0, 2'd1, 2'd1, 8'h00, 8'hE0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{OP_NOP, 2'd2, 2'd1, 2'd1, 8'h77, 8'h00, 1'b0, 8'h20, 1'b0, 1'b1};
    vecs[11] = '{OP_LDI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 8'hE0, 1'b0, 1'b1};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_done_valid", 32'(bus.done_valid), 0);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_alu_b", 32'(bus.alu_b), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    for (int r = 0; r < 4; r++) begin
      bus.dbg_addr = 2'(r);
      #1;
      chk("rst_rf", 32'(bus.dbg_data), 0);
    end
    chk("rst_flag_z", 32'(bus.flag_z), 0);
    chk("rst_flag_c", 32'(bus.flag_c), 0);

    // table-driven ops
    for (int i = 0; i < 12; i++) begin
      bus.dbg_addr = vecs[i].rd;
      issue({vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2}, vecs[i].imm, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 2);
      chk($sformatf("v%0d_done_data", i), 32'(bus.done_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_done_wen", i), 32'(bus.done_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d_done_rd", i), 32'(bus.done_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rd_old_in_wb", i), 32'(bus.dbg_data), 32'(vecs[i].old));
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), 32'(bus.done_valid), 0);
      chk($sformatf("v%0d_rd_new", i), 32'(bus.dbg_data), 32'(vecs[i].wen ? vecs[i].data : vecs[i].old));
      chk($sformatf("v%0d_flag_z", i), 32'(bus.flag_z), 32'(vecs[i].z));
      chk($sformatf("v%0d_flag_c", i), 32'(bus.flag_c), 32'(vecs[i].c));
    end

    // back-to-back dependent ADD r1,r1,r1 with in_valid held high
    issue({OP_LDI, 2'd1, 2'd0, 2'd0}, 8'h01, lat);
    @(negedge clk);
    bus.in_instr = {OP_ADD, 2'd1, 2'd1, 2'd1};
    bus.in_valid = 1'b1;
    k = 0;
    got = '{default: 8'hFF};
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("stream_ready_%0d", i), 32'(bus.in_ready), 32'(i % 3 == 0));
      if (bus.done_valid && k < 3) begin
        got[k] = bus.done_data;
        k++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(k), 3);
    chk("stream_res0", 32'(got[0]), 32'h02);
    chk("stream_res1", 32'(got[1]), 32'h04);
    chk("stream_res2", 32'(got[2]), 32'h08);
    bus.dbg_addr = 2'd1;
    #1;
    chk("stream_r1", 32'(bus.dbg_data), 32'h08);

    // SUB r0,r1,r2 = 0x08-0x20 borrows, so reset below has a set flag to clear
    issue({OP_SUB, 2'd0, 2'd1, 2'd2}, 8'h00, lat);
    chk("pre_abort_data", 32'(bus.done_data), 32'hE8);
    @(negedge clk);
    chk("pre_abort_flag_c", 32'(bus.flag_c), 1);

    // reset during EXEC of LDI r3,0xAA
    bus.in_instr = {OP_LDI, 2'd3, 2'd0, 2'd0};
    bus.in_imm = 8'hAA;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_done_valid", 32'(bus.done_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_release_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(bus.done_valid), 0);
    end
    chk("abort_idle", 32'(bus.in_ready), 1);
    bus.dbg_addr = 2'd3;
    #1;
    chk("abort_r3", 32'(bus.dbg_data), 0);
    bus.dbg_addr = 2'd1;
    #1;
    chk("abort_r1", 32'(bus.dbg_data), 0);
    chk("abort_flag_z", 32'(bus.flag_z), 0);
    chk("abort_flag_c", 32'(bus.flag_c), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
